gcm_input_sequencer: RTL

//  Front end of the GCM-AES pipeline. Accepts one job descriptor (key, IV, byte lengths)
//  and a 128-bit AAD-then-plaintext data stream, and drives the pipeline's stage-1 inputs:
//  one header beat, then one block per beat. Zero-pads partial final blocks and converts

---
 rtl/gcm_input_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gcm_input_sequencer.sv
// gcm_input_sequencer
//   Front end of the GCM-AES pipeline. Takes one job descriptor (key, IV, AAD and
//   plaintext byte lengths) plus an AAD-then-plaintext stream of 128-bit beats, and
//   issues one header beat followed by one block per accepted beat. Partial final
//   blocks are zero-padded; byte lengths are turned into 64-bit bit lengths.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_desc_valid / o_desc_ready    descriptor handshake (ready only while idle)
//   i_key, i_iv                    job key / IV (bit 0 = MSB)
//   i_aad_bytes, i_pt_bytes        job byte lengths
//   i_data_valid / o_data_ready    data beat handshake (ready only in AAD/PT)
//   i_data                         data block, byte 0 = bits [0:7]
//   o_new_instance                 header beat
//   o_pt_instance, o_blk_valid     block type / block present
//   o_cipher_key, o_iv             held for the whole job
//   o_aad, o_plain_text            block on the matching output, other one zero
//   o_aad_size, o_pt_size          bit lengths
//   o_busy                         job in progress
module gcm_input_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_desc_valid,
  output logic             o_desc_ready,
  input  logic [0:127]     i_key,
  input  logic [0:95]      i_iv,
  input  logic [LEN_W-1:0] i_aad_bytes,
  input  logic [LEN_W-1:0] i_pt_bytes,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [0:127]     i_data,
  output logic             o_new_instance,
  output logic             o_pt_instance,
  output logic             o_blk_valid,
  output logic [0:127]     o_cipher_key,
  output logic [0:95]      o_iv,
  output logic [0:127]     o_aad,
  output logic [0:127]     o_plain_text,
  output logic [63:0]      o_aad_size,
  output logic [63:0]      o_pt_size,
  output logic             o_busy
);
  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [1:0] {IDLE, HDR, AAD, PT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] aad_cnt, pt_cnt;
  logic [3:0]       aad_lb, pt_lb;
  logic             desc_acc, beat, last_blk;
  logic [3:0]       lb;
  logic [0:127]     masked;

  function automatic logic [CNT_W-1:0] blocks(input logic [LEN_W-1:0] b);
    logic [LEN_W:0] s;
    s = {1'b0, b} + (LEN_W+1)'(15);
    return s[LEN_W:4];
  endfunction

  assign desc_acc = i_desc_valid & o_desc_ready;
  assign beat     = i_data_valid & o_data_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (desc_acc) state_nx = HDR;
      HDR:  state_nx = (aad_cnt != '0) ? AAD : (pt_cnt != '0) ? PT : IDLE;
      AAD:  if (beat && aad_cnt == CNT_W'(1)) state_nx = (pt_cnt != '0) ? PT : IDLE;
      PT:   if (beat && pt_cnt == CNT_W'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Zero bytes at or beyond the final-block length; lb==0 means a full block.
  always_comb begin
    lb       = (state == AAD) ? aad_lb : pt_lb;
    last_blk = (state == AAD) ? (aad_cnt == CNT_W'(1)) : (pt_cnt == CNT_W'(1));
    masked   = i_data;
    for (int j = 0; j < 16; j++)
      if (last_blk && lb != 4'd0 && j >= int'(lb)) masked[8*j +: 8] = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aad_cnt <= '0;
      pt_cnt  <= '0;
      aad_lb  <= '0;
      pt_lb   <= '0;
    end else if (state == IDLE && desc_acc) begin
      aad_cnt <= blocks(i_aad_bytes);
      pt_cnt  <= blocks(i_pt_bytes);
      aad_lb  <= i_aad_bytes[3:0];
      pt_lb   <= i_pt_bytes[3:0];
    end else if (beat) begin
      if (state == AAD) aad_cnt <= aad_cnt - CNT_W'(1);
      if (state == PT)  pt_cnt  <= pt_cnt - CNT_W'(1);
    end
  end

  // Handshake/status flops follow the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_desc_ready   <= 1'b0;
      o_data_ready   <= 1'b0;
      o_busy         <= 1'b0;
      o_new_instance <= 1'b0;
      o_pt_instance  <= 1'b0;
      o_blk_valid    <= 1'b0;
      o_cipher_key   <= '0;
      o_iv           <= '0;
      o_aad          <= '0;
      o_plain_text   <= '0;
      o_aad_size     <= '0;
      o_pt_size      <= '0;
    end else begin
      o_desc_ready   <= (state_nx == IDLE);
      o_data_ready   <= (state_nx == AAD) || (state_nx == PT);
      o_busy         <= (state_nx != IDLE);
      o_new_instance <= (state_nx == HDR);
      o_blk_valid    <= beat;
      o_pt_instance  <= beat && (state == PT);
      o_aad          <= (beat && state == AAD) ? masked : '0;
      o_plain_text   <= (beat && state == PT)  ? masked : '0;
      if (desc_acc) begin
        o_cipher_key <= i_key;
        o_iv         <= i_iv;
        o_aad_size   <= 64'(i_aad_bytes) << 3;
        o_pt_size    <= 64'(i_pt_bytes) << 3;
      end
    end
  end
endmodule
